// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port on-chip RAM: write bursts via valid/ready,
// read bursts issued back-to-back with returning data tracked by a valid pipe.
module ram_burst_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2,
    parameter int LEN_W  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Write,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [LEN_W-1:0]  Len,
    input  logic [DATA_W-1:0] WrData,
    input  logic              WrValid,
    output logic              WrReady,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamData,
    output logic              RamWren,
    input  logic [DATA_W-1:0] RamQ
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WRITE    = 3'd1;
    localparam logic [2:0] ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] ST_RD_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Pipe pattern seen in the cycle the final read beat is on RdValid.
    localparam logic [RD_LAT-1:0] LAST_ONLY = RD_LAT'(1) << (RD_LAT - 1);

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]  beat_reg, beat_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [ADDR_W-1:0] hold_addr_reg;
    logic [RD_LAT-1:0] vpipe_reg, vpipe_next;
    logic              issue;
    logic              in_write;
    logic              in_issue;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        beat_next  = beat_reg;
        len_next   = len_reg;
        issue      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    addr_next  = BaseAddr;
                    beat_next  = '0;
                    len_next   = Len;
                    state_next = Write ? ST_WRITE : ST_RD_ISSUE;
                end
            end
            ST_WRITE: begin
                if (WrValid) begin
                    addr_next = addr_reg + ADDR_W'(1);
                    beat_next = beat_reg + LEN_W'(1);
                    if (beat_reg == len_reg) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                issue     = 1'b1;
                addr_next = addr_reg + ADDR_W'(1);
                beat_next = beat_reg + LEN_W'(1);
                if (beat_reg == len_reg) begin
                    state_next = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                if (vpipe_reg == LAST_ONLY) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Valid pipe: stage 0 marks an address issued last cycle, stage RD_LAT-1 aligns with q.
    assign vpipe_next[0] = issue;
    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vpipe
            assign vpipe_next[gi] = vpipe_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            beat_reg      <= '0;
            len_reg       <= '0;
            hold_addr_reg <= '0;
            vpipe_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            beat_reg      <= beat_next;
            len_reg       <= len_next;
            hold_addr_reg <= RamAddr;
            vpipe_reg     <= vpipe_next;
        end
    end

    assign in_write = (state_reg == ST_WRITE);
    assign in_issue = (state_reg == ST_RD_ISSUE);

    // Outside active issue the RAM address stays on whatever was last driven.
    assign RamAddr = (in_write || in_issue) ? addr_reg : hold_addr_reg;
    assign RamData = in_write ? WrData : '0;
    assign RamWren = in_write && WrValid;
    assign WrReady = in_write;

    assign RdValid = vpipe_reg[RD_LAT-1];
    assign RdData  = RdValid ? RamQ : '0;

    assign Busy = (state_reg != ST_IDLE);
    assign Done = (state_reg == ST_DONE);

endmodule
